exec_mem_unit: RTL and testbench

- Execute/memory-stage compute block of the 8-bit pipelined processor.
- Combines an 8-bit ALU, an 8-bit barrel shifter (shift/rotate), the carry/zero flag registers, and a 256x8 data memory.
- Pipeline registers, forwarding muxes and writeback selection are outside this block and drive/consume its ports directly.

---
 rtl/exec_mem_unit.sv | 131 +++++++++++++
 tb/tb_exec_mem_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
// Execute/memory-stage compute block: 8-bit ALU, barrel shifter, C/Z flag
// registers and a 256x8 asynchronously-read data memory.
module exec_mem_unit #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   alu_op,
  input  logic [DATA_W-1:0]            alu_a,
  input  logic [DATA_W-1:0]            alu_b,
  input  logic                         use_carry,
  input  logic [2:0]                   bitcount,
  input  logic                         dir,
  input  logic                         sh_robar,
  input  logic                         select_c,
  input  logic                         select_z,
  input  logic                         write_c,
  input  logic                         write_z,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W-1:0]            alu_out,
  output logic                         alu_co,
  output logic                         alu_z,
  output logic [DATA_W-1:0]            shift_out,
  output logic                         shift_c,
  output logic                         shift_z,
  output logic [DATA_W-1:0]            mem_rdata,
  output logic                         c_flag,
  output logic                         z_flag
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOT   = 3'b101,
    OP_PASSB = 3'b110,
    OP_PASSA = 3'b111
  } alu_op_e;

  alu_op_e             op;
  logic                cin;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W:0]     diff_w;
  logic [DATA_W-1:0]   shl;
  logic [DATA_W-1:0]   shr;
  logic                shl_c;
  logic                shr_c;
  logic [3:0]          inv_n;
  logic [DATA_W-1:0]   rotl;
  logic [DATA_W-1:0]   rotr;
  logic                c_flag_d, c_flag_q;
  logic                z_flag_d, z_flag_q;
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  assign op  = alu_op_e'(alu_op);
  assign cin = use_carry & c_flag_q;

  always_comb begin
    sum_w   = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, cin};
    diff_w  = {1'b0, alu_a} - {1'b0, alu_b} - {{DATA_W{1'b0}}, cin};
    alu_out = '0;
    alu_co  = 1'b0;
    case (op)
      OP_ADD:   {alu_co, alu_out} = sum_w;
      OP_SUB:   {alu_co, alu_out} = diff_w;  // MSB of the 9-bit difference is the borrow
      OP_AND:   alu_out = alu_a & alu_b;
      OP_OR:    alu_out = alu_a | alu_b;
      OP_XOR:   alu_out = alu_a ^ alu_b;
      OP_NOT:   alu_out = ~alu_a;
      OP_PASSB: alu_out = alu_b;
      OP_PASSA: alu_out = alu_a;
      default:  alu_out = '0;
    endcase
    alu_z = (alu_out == '0);
  end

  // Extra guard bit on the shifted-out side captures the last bit shifted out.
  always_comb begin
    {shl_c, shl} = {1'b0, alu_a} << bitcount;
    {shr, shr_c} = {alu_a, 1'b0} >> bitcount;
    inv_n        = 4'(DATA_W) - {1'b0, bitcount};
    rotl         = (alu_a << bitcount) | (alu_a >> inv_n);
    rotr         = (alu_a >> bitcount) | (alu_a << inv_n);
    shift_out    = alu_a;
    shift_c      = 1'b0;
    if (bitcount != '0) begin
      case ({sh_robar, dir})
        2'b10:   begin shift_out = shl;  shift_c = shl_c;   end
        2'b11:   begin shift_out = shr;  shift_c = shr_c;   end
        2'b00:   begin shift_out = rotl; shift_c = rotl[0]; end
        default: begin shift_out = rotr; shift_c = rotr[DATA_W-1]; end
      endcase
    end
    shift_z = (shift_out == '0);
  end

  always_comb begin
    c_flag_d = c_flag_q;
    z_flag_d = z_flag_q;
    if (write_c) c_flag_d = select_c ? shift_c : alu_co;
    if (write_z) z_flag_d = select_z ? shift_z : alu_z;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      c_flag_q <= c_flag_d;
      z_flag_q <= z_flag_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_q[mem_addr];
  assign c_flag    = c_flag_q;
  assign z_flag    = z_flag_q;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit: ALU, shifter, flags, memory, reset.
module tb_exec_mem_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       use_carry;
  logic [2:0] bitcount;
  logic       dir, sh_robar, select_c, select_z, write_c, write_z, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] alu_out, shift_out, mem_rdata;
  logic       alu_co, alu_z, shift_c, shift_z, c_flag, z_flag;

  int tests = 0;
  int fails = 0;

  exec_mem_unit #(.DATA_W(8), .MEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .use_carry(use_carry), .bitcount(bitcount), .dir(dir), .sh_robar(sh_robar),
    .select_c(select_c), .select_z(select_z), .write_c(write_c), .write_z(write_z),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z),
    .shift_out(shift_out), .shift_c(shift_c), .shift_z(shift_z),
    .mem_rdata(mem_rdata), .c_flag(c_flag), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic uc);
    alu_op = op; alu_a = a; alu_b = b; use_carry = uc;
  endtask

  task automatic sh(input logic [7:0] a, input logic [2:0] n, input logic d,
                    input logic robar);
    alu_a = a; bitcount = n; dir = d; sh_robar = robar;
  endtask

  initial begin
    reset = 1'b1;
    alu_op = 3'd0; alu_a = 8'h00; alu_b = 8'h00; use_carry = 1'b0;
    bitcount = 3'd0; dir = 1'b0; sh_robar = 1'b0;
    select_c = 1'b0; select_z = 1'b0; write_c = 1'b0; write_z = 1'b0;
    mem_we = 1'b0; mem_addr = 8'h00; mem_wdata = 8'h00;
    #1;
    chk("reset_c", {7'd0, c_flag}, 8'h00);
    chk("reset_z", {7'd0, z_flag}, 8'h00);
    chk("reset_mem", mem_rdata, 8'h00);
    @(negedge clk); reset = 1'b0;

    // ADD FF+01 with flag writes
    @(negedge clk);
    alu(3'b000, 8'hFF, 8'h01, 1'b0); write_c = 1'b1; write_z = 1'b1;
    #1;
    chk("add_out", alu_out, 8'h00);
    chk("add_co", {7'd0, alu_co}, 8'h01);
    chk("add_z", {7'd0, alu_z}, 8'h01);
    @(posedge clk); #1;
    chk("add_cflag", {7'd0, c_flag}, 8'h01);
    chk("add_zflag", {7'd0, z_flag}, 8'h01);

    // ADC using stored carry, flags held
    @(negedge clk);
    write_c = 1'b0; write_z = 1'b0; alu(3'b000, 8'h10, 8'h20, 1'b1);
    #1;
    chk("adc_out", alu_out, 8'h31);
    chk("adc_co", {7'd0, alu_co}, 8'h00);
    @(posedge clk); #1;
    chk("adc_chold", {7'd0, c_flag}, 8'h01);

    // SUB / SBC
    @(negedge clk);
    alu(3'b001, 8'h05, 8'h07, 1'b0); #1;
    chk("sub_out", alu_out, 8'hFE);
    chk("sub_co", {7'd0, alu_co}, 8'h01);
    chk("sub_z", {7'd0, alu_z}, 8'h00);
    alu(3'b001, 8'h07, 8'h07, 1'b0); #1;
    chk("sub0_out", alu_out, 8'h00);
    chk("sub0_co", {7'd0, alu_co}, 8'h00);
    chk("sub0_z", {7'd0, alu_z}, 8'h01);
    alu(3'b001, 8'h10, 8'h05, 1'b1); #1;
    chk("sbc_out", alu_out, 8'h0A);
    chk("sbc_co", {7'd0, alu_co}, 8'h00);
    alu(3'b001, 8'hFF, 8'hFF, 1'b1); #1;
    chk("sbc_bor_out", alu_out, 8'hFF);
    chk("sbc_bor_co", {7'd0, alu_co}, 8'h01);

    // Logic ops
    alu(3'b010, 8'hF0, 8'h3C, 1'b1); #1;
    chk("and_out", alu_out, 8'h30);
    chk("and_co", {7'd0, alu_co}, 8'h00);
    alu(3'b011, 8'hF0, 8'h0F, 1'b0); #1; chk("or_out", alu_out, 8'hFF);
    alu(3'b100, 8'hFF, 8'h0F, 1'b0); #1; chk("xor_out", alu_out, 8'hF0);
    alu(3'b101, 8'h0F, 8'hAA, 1'b0); #1; chk("not_out", alu_out, 8'hF0);
    alu(3'b110, 8'h5A, 8'h00, 1'b0); #1;
    chk("passb_out", alu_out, 8'h00);
    chk("passb_z", {7'd0, alu_z}, 8'h01);
    alu(3'b111, 8'h5A, 8'h00, 1'b0); #1; chk("passa_out", alu_out, 8'h5A);

    // Shifter
    sh(8'h81, 3'd1, 1'b0, 1'b1); #1;
    chk("shl_out", shift_out, 8'h02);
    chk("shl_c", {7'd0, shift_c}, 8'h01);
    sh(8'h01, 3'd1, 1'b1, 1'b1); #1;
    chk("shr_out", shift_out, 8'h00);
    chk("shr_c", {7'd0, shift_c}, 8'h01);
    chk("shr_z", {7'd0, shift_z}, 8'h01);
    sh(8'h01, 3'd1, 1'b1, 1'b0); #1;
    chk("rotr_out", shift_out, 8'h80);
    chk("rotr_c", {7'd0, shift_c}, 8'h01);
    sh(8'h96, 3'd0, 1'b0, 1'b0); #1;
    chk("rotl0_out", shift_out, 8'h96);
    chk("rotl0_c", {7'd0, shift_c}, 8'h00);
    sh(8'h96, 3'd3, 1'b1, 1'b1); #1;
    chk("shr3_out", shift_out, 8'h12);
    chk("shr3_c", {7'd0, shift_c}, 8'h01);
    sh(8'h96, 3'd3, 1'b0, 1'b0); #1;
    chk("rotl3_out", shift_out, 8'hB4);
    chk("rotl3_c", {7'd0, shift_c}, 8'h00);
    sh(8'hFF, 3'd7, 1'b0, 1'b1); #1;
    chk("shl7_out", shift_out, 8'h80);
    chk("shl7_c", {7'd0, shift_c}, 8'h01);

    // Flag source selection: clear C, set Z via ALU
    @(negedge clk);
    alu(3'b000, 8'h00, 8'h00, 1'b0); select_c = 1'b0; select_z = 1'b0;
    write_c = 1'b1; write_z = 1'b1;
    @(posedge clk); #1;
    chk("sel_pre_c", {7'd0, c_flag}, 8'h00);
    chk("sel_pre_z", {7'd0, z_flag}, 8'h01);
    @(negedge clk);
    alu(3'b000, 8'h81, 8'h00, 1'b0); sh(8'h81, 3'd1, 1'b0, 1'b1);
    select_c = 1'b1; write_c = 1'b1; write_z = 1'b0;
    @(posedge clk); #1;
    chk("selc_cflag", {7'd0, c_flag}, 8'h01);
    chk("selc_zhold", {7'd0, z_flag}, 8'h01);
    @(negedge clk);
    alu(3'b110, 8'h81, 8'h00, 1'b0); select_z = 1'b1; write_c = 1'b0; write_z = 1'b1;
    @(posedge clk); #1;
    chk("selz_zflag", {7'd0, z_flag}, 8'h00);
    chk("selz_chold", {7'd0, c_flag}, 8'h01);
    @(negedge clk); write_z = 1'b0; select_c = 1'b0; select_z = 1'b0;

    // Memory
    mem_we = 1'b1; mem_addr = 8'h10; mem_wdata = 8'hA5; #1;
    chk("mem_old", mem_rdata, 8'h00);
    @(posedge clk); #1;
    chk("mem_new", mem_rdata, 8'hA5);
    @(negedge clk); mem_addr = 8'hFF; mem_wdata = 8'h3C;
    @(negedge clk); mem_we = 1'b0;
    mem_addr = 8'h10; #1; chk("mem_rd10", mem_rdata, 8'hA5);
    mem_addr = 8'hFF; #1; chk("mem_rdFF", mem_rdata, 8'h3C);
    mem_addr = 8'h11; #1; chk("mem_rd11", mem_rdata, 8'h00);

    // Reset mid-operation discards pending write and flag update
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 8'h10; mem_wdata = 8'h77;
    alu(3'b000, 8'h00, 8'h00, 1'b0); write_c = 1'b1; write_z = 1'b1;
    #2 reset = 1'b1; #1;
    chk("rst_async_c", {7'd0, c_flag}, 8'h00);
    chk("rst_async_mem", mem_rdata, 8'h00);
    chk("rst_comb_alu_z", {7'd0, alu_z}, 8'h01);
    @(posedge clk); #1;
    chk("rst_wr_ignored", mem_rdata, 8'h00);
    chk("rst_z", {7'd0, z_flag}, 8'h00);
    @(negedge clk);
    mem_we = 1'b0; write_c = 1'b0; write_z = 1'b0; reset = 1'b0;
    mem_addr = 8'hFF; #1;
    chk("post_rst_memFF", mem_rdata, 8'h00);
    chk("post_rst_c", {7'd0, c_flag}, 8'h00);
    chk("post_rst_z", {7'd0, z_flag}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
